// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants and fetch FSM states.
package cpu_pkg;

  localparam int unsigned PC_WIDTH  = 8;
  localparam int unsigned OPC_WIDTH = 3;
  localparam int unsigned IMM_WIDTH = 3;

  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 3'b000;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 3'b001;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 3'b010;
  localparam logic [OPC_WIDTH-1:0] OPC_LW   = 3'b011;
  localparam logic [OPC_WIDTH-1:0] OPC_SW   = 3'b100;
  localparam logic [OPC_WIDTH-1:0] OPC_BEQ  = 3'b101;
  localparam logic [OPC_WIDTH-1:0] OPC_JMP  = 3'b110;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT = 3'b111;

  typedef enum logic [1:0] {
    FS_RUN     = 2'd0,
    FS_STALLED = 2'd1,
    FS_HALTED  = 2'd2
  } fetch_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: reset > jump > branch > hold > increment, all modulo 2^PC_WIDTH.
module pc_next_mux #(
  parameter int unsigned          PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                reset,
  input  logic                jump,
  input  logic                branch,
  input  logic                hold,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] if_id_pc,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] pc_next
);

  logic [PC_WIDTH-1:0] branch_target;

  // Offset is two's complement, so a plain truncating add wraps in both directions.
  assign branch_target = if_id_pc + PC_WIDTH'(1) + branch_offset;

  always_comb begin
    pc_next = pc + PC_WIDTH'(1);
    if (reset) begin
      pc_next = RESET_PC;
    end else if (jump) begin
      pc_next = jump_target;
    end else if (branch) begin
      pc_next = branch_target;
    end else if (hold) begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, the IF/ID register, stall/redirect/halt control and a fetch counter.
module pc_fetch_unit #(
  parameter int unsigned                    PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]            RESET_PC    = '0,
  parameter logic [cpu_pkg::OPC_WIDTH-1:0]  HALT_OPCODE = cpu_pkg::OPC_HALT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [cpu_pkg::OPC_WIDTH-1:0]     opcode_in,
  input  logic                              rs_in,
  input  logic                              rt_rd_in,
  input  logic [cpu_pkg::IMM_WIDTH-1:0]     imm_in,
  input  logic                              stall,
  input  logic                              branch_en,
  input  logic [PC_WIDTH-1:0]               branch_offset,
  input  logic                              jump_en,
  input  logic [PC_WIDTH-1:0]               jump_target,
  output logic [PC_WIDTH-1:0]               pc,
  output logic                              if_id_valid,
  output logic [cpu_pkg::OPC_WIDTH-1:0]     if_id_opcode,
  output logic                              if_id_rs,
  output logic                              if_id_rt_rd,
  output logic [cpu_pkg::IMM_WIDTH-1:0]     if_id_imm,
  output logic [PC_WIDTH-1:0]               if_id_pc,
  output logic                              halted,
  output logic [7:0]                        fetch_count
);
  import cpu_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_next;
  logic                jump_take, branch_take, redirect, fetch, halt_hit, hold_pc;

  always_comb begin
    jump_take   = jump_en && (state_q != FS_HALTED);
    branch_take = branch_en && !jump_en && (state_q != FS_HALTED);
    redirect    = jump_take || branch_take;
    fetch       = (state_q != FS_HALTED) && !stall && !redirect;
    halt_hit    = fetch && (opcode_in == HALT_OPCODE);
    hold_pc     = (state_q == FS_HALTED) || stall || halt_hit;

    state_d = FS_RUN;
    if (redirect) begin
      state_d = FS_RUN;
    end else if (state_q == FS_HALTED || halt_hit) begin
      state_d = FS_HALTED;
    end else if (stall) begin
      state_d = FS_STALLED;
    end
  end

  pc_next_mux #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_next_mux (
    .reset         (reset),
    .jump          (jump_take),
    .branch        (branch_take),
    .hold          (hold_pc),
    .pc            (pc_q),
    .if_id_pc      (if_id_pc),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk) begin
    pc_q <= pc_next;
    if (reset) begin
      state_q      <= FS_RUN;
      if_id_valid  <= 1'b0;
      if_id_opcode <= '0;
      if_id_rs     <= 1'b0;
      if_id_rt_rd  <= 1'b0;
      if_id_imm    <= '0;
      if_id_pc     <= '0;
      fetch_count  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect || state_q == FS_HALTED) begin
        if_id_valid <= 1'b0;
      end else if (fetch) begin
        if_id_valid  <= 1'b1;
        if_id_opcode <= opcode_in;
        if_id_rs     <= rs_in;
        if_id_rt_rd  <= rt_rd_in;
        if_id_imm    <= imm_in;
        if_id_pc     <= pc_q;
        fetch_count  <= sat_inc8(fetch_count);
      end
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == FS_HALTED);

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage directly upstream of instruction_memory. Owns the 8-bit program counter driven into instruction_memory.pc and consumes the decoded fields it returns (opcode, rs, rt/rd, 3-bit immediate). Captures those fields into an IF/ID pipeline register for the control unit and sign-extension stage. Handles stall, branch/jump redirect with flush, and halt-on-opcode.

Parameters:
PC_WIDTH, 8, program counter width; also the IF/ID pc width.
RESET_PC, 8'h00, PC value loaded on reset.
HALT_OPCODE, 3'b111, opcode that stops fetch once latched.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode_in  input  3  from instruction_memory output_ctrl_unit_opcode
rs_in  input  1  from instruction_memory output_rs_reg
rt_rd_in  input  1  from instruction_memory output_rt_rd_reg
imm_in  input  3  from instruction_memory input_sign_extension_immediate
stall  input  1  downstream hazard; hold PC and IF/ID
branch_en  input  1  taken branch resolved for the IF/ID instruction
branch_offset  input  8  signed two's-complement offset, relative to if_id_pc+1
jump_en  input  1  absolute redirect
jump_target  input  8  absolute jump address
pc  output  8  address to instruction_memory
if_id_valid  output  1  IF/ID register holds a real instruction
if_id_opcode  output  3  latched opcode
if_id_rs  output  1  latched rs
if_id_rt_rd  output  1  latched rt/rd
if_id_imm  output  3  latched immediate
if_id_pc  output  8  PC of latched instruction
halted  output  1  high in HALTED state
fetch_count  output  8  number of instructions latched valid, saturating

Behaviour:
- One clock, synchronous active-high reset; clock port clk, reset port reset. All state updates on the rising edge of clk.
- Reset values: pc=RESET_PC, if_id_valid=0, all if_id_* fields=0, halted=0, fetch_count=0, state=RUN. Reset overrides every other input, including mid-stall and mid-halt.
- instruction_memory is combinational. The fields present during a cycle belong to the current pc, so latency from pc to the IF/ID register is 1 cycle.
- States: RUN, STALLED, HALTED, encoded 2'd0/1/2. Per-cycle priority: reset > jump_en > branch_en > HALTED hold > stall > halt detect > normal fetch.
- Normal fetch in RUN with no stall: pc<=pc+1, wrapping 8'hFF->8'h00. IF/ID <= {fields, pc}, if_id_valid<=1, fetch_count<=fetch_count+1, saturating at 8'hFF.
- Stall (RUN or STALLED): pc, IF/ID and fetch_count hold; state<=STALLED. When stall deasserts, state<=RUN and normal fetch resumes that same cycle.
- Jump: pc<=jump_target, if_id_valid<=0 (flush), state<=RUN. If branch_en is asserted in the same cycle it is ignored. Jump overrides stall.
- Branch: pc<=if_id_pc+8'd1+branch_offset, modulo 256 with wrap in both directions; flush; state<=RUN. Branch overrides stall.
- Redirects are honoured only in RUN or STALLED; in HALTED they are ignored.
- Halt detect: in RUN with no stall or redirect, if opcode_in==HALT_OPCODE:
  - latch the instruction as normal (valid=1, count increments);
  - pc holds;
  - state<=HALTED, halted<=1.
- HALTED: pc holds; if_id_valid<=0 from the next cycle; fetch_count holds; only reset exits.
- A halt opcode present during a stall or redirect cycle is not acted on.

Decomposition:
- Shared package (cpu_pkg): PC_WIDTH, opcode width 3, immediate width 3, opcode constants including OPC_HALT=3'b111, fetch state enum {FS_RUN, FS_STALLED, FS_HALTED}.
- One natural sub-module, pc_next_mux: combinational next-PC selection (reset/jump/branch/hold/increment) plus the branch adder with wrap.
- The FSM, IF/ID register and counter stay in pc_fetch_unit.

Test Plan:
- Reset then 5 cycles, memory returning opcode 3'b001 -> pc runs 0,1,2,3,4,5. IF/ID pc lags by one cycle (0..4), if_id_valid=1 from cycle 1, fetch_count=5.
- Stall 3 cycles at pc=3 -> pc stays 3 and IF/ID stays {instr@2, pc=2}. State reads STALLED, then RUN with pc=4 on the cycle after stall drops.
- if_id_pc=8'h10, branch_en with offset 8'hFC (-4) -> pc=8'h0D next cycle, if_id_valid=0. Offset 8'h7F at if_id_pc=8'hF0 -> pc=8'h70 (wrap).
- jump_en and branch_en together with jump_target=8'h40, and stall also high -> pc=8'h40, flush, state RUN.
- Opcode 3'b111 fetched at pc=6 -> IF/ID latches pc=6 valid. Then halted=1, pc stays 6, if_id_valid=0 next cycle. A jump during HALTED is ignored.
- pc=8'hFF normal fetch -> pc=8'h00. Reset asserted during HALTED -> pc=RESET_PC, halted=0, fetch_count=0.
